// File: rtl/pipelined_signed_shift_divide_by_pow2.sv
// ---------------------------------------------------------------------------
// pipelined_signed_shift_divide_by_pow2
//
// Streaming signed divide by 2^s with a per-transaction shift amount and
// rounding mode (floor = arithmetic right shift, trunc = round toward zero).
// Two registered stages with a valid/ready handshake; one transaction per
// cycle while downstream is ready, and full backpressure without a skid buffer.
//
// Ports
//   clk         rising-edge clock
//   rst         asynchronous, active-high reset; flushes both stages
//   in_valid    upstream transaction valid
//   in_ready    block can accept a transaction this cycle (combinational
//               from out_ready)
//   in_a        signed dividend, N bits
//   in_s        unsigned shift amount, SW bits; values >= N act as N
//   in_trunc    0 = floor, 1 = truncate toward zero
//   out_valid   result valid
//   out_ready   downstream accepts the result this cycle
//   out_q       signed quotient, N bits
//   out_inexact 1 when any bit shifted out of in_a was nonzero
// ---------------------------------------------------------------------------
module pipelined_signed_shift_divide_by_pow2 #(
    parameter int N  = 8,
    parameter int SW = $clog2(N) + 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [N-1:0]  in_a,
    input  logic [SW-1:0] in_s,
    input  logic          in_trunc,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [N-1:0]  out_q,
    output logic          out_inexact
);

    localparam logic [SW-1:0] S_MAX = SW'(N);

    // Stage 1 combinational
    logic [SW-1:0] w_s_eff;
    logic [N:0]    w_a_ext;
    logic [N:0]    w_mask;
    logic [N:0]    w_bias;
    logic [N:0]    w_sum;
    logic          w_inexact;
    logic          w_s1_advance;

    // Stage 1 registers
    logic          r_s1_valid;
    logic [N:0]    r_s1_sum;
    logic [SW-1:0] r_s1_s;
    logic          r_s1_inexact;

    // Stage 2 registers
    logic          r_s2_valid;
    logic [N-1:0]  r_s2_q;
    logic          r_s2_inexact;

    // Barrel shifter
    logic [N:0]    w_stg [SW];
    logic [N-1:0]  w_q;

    assign w_s1_advance = !r_s2_valid || out_ready;
    assign in_ready     = !r_s1_valid || w_s1_advance;

    // Truncation toward zero is floor of (a + 2^s - 1) for negative a; the
    // bias is added at N+1 bits so the sum never wraps.
    always_comb begin
        w_s_eff   = (in_s > S_MAX) ? S_MAX : in_s;
        w_a_ext   = {in_a[N-1], in_a};
        w_mask    = ~({(N+1){1'b1}} << w_s_eff);
        w_inexact = |(w_a_ext & w_mask);
        w_bias    = (in_trunc && in_a[N-1]) ? w_mask : '0;
        w_sum     = w_a_ext + w_bias;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_s1_valid   <= 1'b0;
            r_s1_sum     <= '0;
            r_s1_s       <= '0;
            r_s1_inexact <= 1'b0;
        end else if (in_ready) begin
            r_s1_valid <= in_valid;
            if (in_valid) begin
                r_s1_sum     <= w_sum;
                r_s1_s       <= w_s_eff;
                r_s1_inexact <= w_inexact;
            end
        end
    end

    // Arithmetic right shift of the N+1-bit sum, one stage per bit of the
    // shift amount. The last stage emits only the N result LSBs, which is
    // equivalent because bit N of the source equals its sign.
    assign w_stg[0] = r_s1_sum;

    for (genvar k = 0; k < SW; k++) begin : g_barrel
        localparam int SH = 1 << k;
        if (k < SW - 1) begin : g_mid
            if (SH > N) begin : g_fill
                assign w_stg[k+1] = r_s1_s[k] ? {(N+1){w_stg[k][N]}} : w_stg[k];
            end else begin : g_cat
                assign w_stg[k+1] = r_s1_s[k] ? {{SH{w_stg[k][N]}}, w_stg[k][N:SH]}
                                              : w_stg[k];
            end
        end else begin : g_last
            if (SH >= N) begin : g_fill
                assign w_q = r_s1_s[k] ? {N{w_stg[k][N]}} : w_stg[k][N-1:0];
            end else begin : g_cat
                assign w_q = r_s1_s[k] ? {{SH{w_stg[k][N]}}, w_stg[k][N-1:SH]}
                                       : w_stg[k][N-1:0];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_s2_valid   <= 1'b0;
            r_s2_q       <= '0;
            r_s2_inexact <= 1'b0;
        end else if (w_s1_advance) begin
            r_s2_valid <= r_s1_valid;
            if (r_s1_valid) begin
                r_s2_q       <= w_q;
                r_s2_inexact <= r_s1_inexact;
            end
        end
    end

    assign out_valid   = r_s2_valid;
    assign out_q       = r_s2_q;
    assign out_inexact = r_s2_inexact;

endmodule
